sysbus_arbiter: RTL
===================

Name: sysbus_arbiter

Overview:
Two-master arbiter that shares the single Sysbus port between the core's instruction-fetch unit (m0) and the load/store unit (m1).
- Allows exactly one transaction outstanding on the bus at a time.
- Grants round-robin, drives the bus request, streams write data, and steers read response beats back to the owning master.
- Sits between the core's front/back ends and the top-level Sysbus interface.

Parameters:
DATA_W, 64, width of req/resp words
TAG_W, 13, width of reqtag/resptag; MSB = bus READ(1)/WRITE(0) encoding
BEATS, 8, data beats per transaction (one 64-byte line)

Ports:
clk  in  1  core clock (bus.clk)
reset  in  1  synchronous active-high reset (bus.reset)
m0_reqcyc  in  1  fetch request valid; held until m0_reqack
m0_req  in  DATA_W  fetch address
m0_reqtag  in  TAG_W  fetch tag
m0_reqack  out  1  one-cycle accept pulse to fetch
m0_wdata  in  DATA_W  fetch write data (normally unused)
m0_wpop  out  1  fetch write-beat consumed
m0_resp  out  DATA_W  response beat to fetch
m0_respcyc  out  1  response beat valid to fetch
m1_*  same set as m0_*, for load/store unit
bus_reqcyc  out  1  Sysbus request valid
bus_req  out  DATA_W  Sysbus address / write data
bus_reqtag  out  TAG_W  Sysbus tag
bus_reqack  in  1  Sysbus request accepted
bus_resp  in  DATA_W  Sysbus response data
bus_resptag  in  TAG_W  Sysbus response tag
bus_respcyc  in  1  Sysbus response beat valid
bus_respack  out  1  response beat accepted
protocol_err  out  1  sticky error flag

Behaviour:
- Single clock. Reset is synchronous active-high.
  - Reset forces state=IDLE, rr_last=m1 so m0 wins the first tie, and beat_cnt=0.
  - All outputs reset to 0: bus_reqcyc, bus_req, bus_reqtag, m*_reqack, m*_wpop, m*_respcyc, m*_resp, bus_respack, protocol_err.
  - Reset mid-transaction abandons it with no acks or beats issued afterwards.
- Four states: IDLE, REQ, WDATA, RESP. owner (1 bit) records the granted master.
- IDLE:
  - If any mX_reqcyc is high, grant one master: the sole requester, or on a tie the master not equal to rr_last.
  - Register owner, rr_last, bus_req<=mX_req and bus_reqtag<=mX_reqtag, then go to REQ. bus_reqcyc is high from the next cycle on.
  - Grant latency is 1 cycle from request to bus_reqcyc.
- REQ:
  - bus_reqcyc=1; bus_req and bus_reqtag are held stable.
  - On bus_reqack, assert m[owner]_reqack combinationally in the same cycle and set beat_cnt=0.
  - Next state is WDATA if tag MSB=WRITE, else RESP.
  - The requester drops reqcyc the cycle after its ack. The non-owner never sees reqack.
- WDATA:
  - Each cycle: bus_reqcyc=1, bus_req=m[owner]_wdata (combinational), m[owner]_wpop=1, beat_cnt++.
  - After beat BEATS-1 go to IDLE. Exactly BEATS consecutive cycles.
- RESP:
  - bus_respack=bus_respcyc.
  - m[owner]_respcyc=bus_respcyc and m[owner]_resp=bus_resp, both combinational (zero latency).
  - beat_cnt increments per beat. After beat BEATS-1 go to IDLE.
  - Gaps between beats are allowed.
- Non-owner m*_respcyc, m*_reqack and m*_wpop are always 0.
- beat_cnt is $clog2(BEATS) bits wide. It never wraps, because the exit occurs at BEATS-1.
- protocol_err is set and held until reset on any of:
  - bus_respcyc while state != RESP. bus_respack stays 0 for such a stray beat, and the beat is dropped.
  - bus_reqack while state != REQ.
  - bus_resptag[7:0] != bus_reqtag[7:0] on a RESP beat. The beat is still delivered.
- Back-to-back operation:
  - A request pending when RESP or WDATA ends is granted in the IDLE cycle that follows.
  - The minimum gap between transactions is 1 IDLE cycle.
- Simultaneous events:
  - An mX_reqcyc rise during REQ, WDATA or RESP waits; no preemption.
  - Grant uses only values sampled in IDLE.

Test Plan:
- Single read: m0 reqcyc with addr 0x1000 and READ tag; bus acks at cycle 3, then 8 beats 0x11..0x88 → bus_reqcyc high from cycle 1, m0_reqack pulses at 3, m0 receives 8 beats in order, m1_respcyc stays 0, back to IDLE.
- Tie round-robin: m0 and m1 both request from reset → m0 is granted first. After completion m1 is granted; m0 re-requests immediately and is granted third.
- Write: m1 WRITE to 0x2000, ack, then wdata 0xA0..0xA7 → bus_req carries 0xA0..0xA7 on 8 consecutive cycles with m1_wpop=1 each, followed by IDLE. No response routing occurs.
- Gapped response: beats arrive with 2-cycle bubbles → beat_cnt advances only on respcyc, all 8 beats are delivered, and the exit occurs after the 8th beat.
- Reset mid-RESP after 3 beats → the next cycle shows all outputs 0 and state IDLE. A fresh m1 request then completes normally.
- Stray respcyc in IDLE, or resptag id mismatch → protocol_err=1 and sticky, bus_respack=0 for the stray beat, cleared only by reset.

Source files
------------

// File: rtl/sysbus_arbiter_if.sv
// rtl/sysbus_arbiter_if.sv - signal bundle between fetch, load/store, the Sysbus port and the arbiter
//
// Purpose: groups the two core master channels (m0 = fetch, m1 = load/store),
// the shared Sysbus request/response port and the sticky error flag.
// Ports (signals):
//   m0_*/m1_*  : reqcyc, req, reqtag, wdata (to arbiter);
//                reqack, wpop, resp, respcyc (from arbiter)
//   bus_*      : reqcyc, req, reqtag, respack (from arbiter);
//                reqack, resp, resptag, respcyc (to arbiter)
//   protocol_err : sticky protocol violation flag (from arbiter)
// Modports: slave = arbiter view, master = environment view.
interface sysbus_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              m0_reqcyc;
  logic [DATA_W-1:0] m0_req;
  logic [TAG_W-1:0]  m0_reqtag;
  logic              m0_reqack;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_wpop;
  logic [DATA_W-1:0] m0_resp;
  logic              m0_respcyc;

  logic              m1_reqcyc;
  logic [DATA_W-1:0] m1_req;
  logic [TAG_W-1:0]  m1_reqtag;
  logic              m1_reqack;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_wpop;
  logic [DATA_W-1:0] m1_resp;
  logic              m1_respcyc;

  logic              bus_reqcyc;
  logic [DATA_W-1:0] bus_req;
  logic [TAG_W-1:0]  bus_reqtag;
  logic              bus_reqack;
  logic [DATA_W-1:0] bus_resp;
  logic [TAG_W-1:0]  bus_resptag;
  logic              bus_respcyc;
  logic              bus_respack;

  logic              protocol_err;

  modport slave (
    input  m0_reqcyc, m0_req, m0_reqtag, m0_wdata,
    output m0_reqack, m0_wpop, m0_resp, m0_respcyc,
    input  m1_reqcyc, m1_req, m1_reqtag, m1_wdata,
    output m1_reqack, m1_wpop, m1_resp, m1_respcyc,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_resp, bus_resptag, bus_respcyc,
    output protocol_err
  );

  modport master (
    output m0_reqcyc, m0_req, m0_reqtag, m0_wdata,
    input  m0_reqack, m0_wpop, m0_resp, m0_respcyc,
    output m1_reqcyc, m1_req, m1_reqtag, m1_wdata,
    input  m1_reqack, m1_wpop, m1_resp, m1_respcyc,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_resp, bus_resptag, bus_respcyc,
    input  protocol_err
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - round-robin two-master arbiter for the single Sysbus port
//
// Purpose: shares one Sysbus port between fetch (m0) and load/store (m1) with a
// single outstanding transaction, round-robin grant, write-beat streaming and
// response steering back to the owning master.
// Ports:
//   clk   : core clock
//   reset : synchronous active-high reset
//   sb    : sysbus_arbiter_if.slave bundle (m0_*, m1_*, bus_*, protocol_err)
module sysbus_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = 8
) (
  input logic            clk,
  input logic            reset,
  sysbus_arbiter_if.slave sb
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t            state, state_n;
  logic              owner, owner_n;
  logic              rr_last, rr_last_n;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
  logic [DATA_W-1:0] req_q, req_n;
  logic [TAG_W-1:0]  tag_q, tag_n;
  logic              err_q, err_n;

  logic              grant;
  logic              reqack_c;
  logic              wpop_c;
  logic              respcyc_c;
  logic              bus_reqcyc_c;
  logic [DATA_W-1:0] bus_req_c;

  // Only the low 8 tag bits form the transaction id compared on responses.
  logic unused_resptag_hi;
  assign unused_resptag_hi = ^sb.bus_resptag[TAG_W-1:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;  // m0 wins the first tie
      beat_cnt <= '0;
      req_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_last  <= rr_last_n;
      beat_cnt <= beat_cnt_n;
      req_q    <= req_n;
      tag_q    <= tag_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    rr_last_n    = rr_last;
    beat_cnt_n   = beat_cnt;
    req_n        = req_q;
    tag_n        = tag_q;
    grant        = 1'b0;
    reqack_c     = 1'b0;
    wpop_c       = 1'b0;
    respcyc_c    = 1'b0;
    bus_reqcyc_c = 1'b0;
    bus_req_c    = req_q;

    case (state)
      IDLE: begin
        if (sb.m0_reqcyc || sb.m1_reqcyc) begin
          // Tie goes to the master that was not granted last time.
          grant     = (sb.m0_reqcyc && sb.m1_reqcyc) ? ~rr_last : sb.m1_reqcyc;
          owner_n   = grant;
          rr_last_n = grant;
          req_n     = grant ? sb.m1_req : sb.m0_req;
          tag_n     = grant ? sb.m1_reqtag : sb.m0_reqtag;
          state_n   = REQ;
        end
      end
      REQ: begin
        bus_reqcyc_c = 1'b1;
        if (sb.bus_reqack) begin
          reqack_c   = 1'b1;
          beat_cnt_n = '0;
          state_n    = tag_q[TAG_W-1] ? RESP : WDATA;  // MSB: 1 = read
        end
      end
      WDATA: begin
        bus_reqcyc_c = 1'b1;
        bus_req_c    = owner ? sb.m1_wdata : sb.m0_wdata;
        wpop_c       = 1'b1;
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        respcyc_c = sb.bus_respcyc;
        if (sb.bus_respcyc) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Sticky: stray response beat, stray request ack, or response id mismatch.
    err_n = err_q
          | (sb.bus_respcyc && (state != RESP))
          | (sb.bus_reqack && (state != REQ))
          | ((state == RESP) && sb.bus_respcyc && (sb.bus_resptag[7:0] != tag_q[7:0]));
  end

  assign sb.bus_reqcyc   = bus_reqcyc_c;
  assign sb.bus_req      = bus_req_c;
  assign sb.bus_reqtag   = tag_q;
  assign sb.bus_respack  = respcyc_c;
  assign sb.protocol_err = err_q;

  assign sb.m0_reqack  = reqack_c  & ~owner;
  assign sb.m1_reqack  = reqack_c  &  owner;
  assign sb.m0_wpop    = wpop_c    & ~owner;
  assign sb.m1_wpop    = wpop_c    &  owner;
  assign sb.m0_respcyc = respcyc_c & ~owner;
  assign sb.m1_respcyc = respcyc_c &  owner;
  assign sb.m0_resp    = ((state == RESP) && !owner) ? sb.bus_resp : '0;
  assign sb.m1_resp    = ((state == RESP) &&  owner) ? sb.bus_resp : '0;

endmodule
